vector_mem_sequencer: RTL and testbench

Multi-cycle sequencer that turns a single vector load (`cargar vector`) or vector store (`guardar vector`) into LANES element-wide accesses on the single-port scalar data memory. It sits between the control unit / memory stage and data memory, freezes the pipeline with `stall` while it owns the memory, assembles loaded lanes into one vector word, and counts occupied cycles for the performance counters.

---
 rtl/vector_mem_sequencer.sv | 151 +++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: splits one vector access into LANES
// scalar memory accesses and stalls the pipeline while it runs.
module vector_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_load,
  input  logic                    start_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*DATA_W-1:0] store_vec,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    stall,
  output logic [LANES*DATA_W-1:0] load_vec,
  output logic                    load_valid,
  output logic                    store_done,
  output logic                    proto_err,
  output logic [18:0]             busy_count
);

  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] IDX_LAST = IW'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LAST, S_WRITE, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_prev;
  logic [ADDR_W-1:0] r_base;
  logic              r_is_load;
  logic              r_perr;
  logic [18:0]       r_busy;
  logic [DATA_W-1:0] r_sv  [LANES];
  logic [DATA_W-1:0] r_buf [LANES];
  logic [DATA_W-1:0] r_lv  [LANES];
  logic              w_start;
  logic              w_active;

  assign w_start  = start_load | start_store;
  assign w_prev   = r_idx - IW'(1);
  assign w_active = (r_state == S_READ) |
                    (r_state == S_LAST) |
                    (r_state == S_WRITE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_load)       w_next = S_READ;
        else if (start_store) w_next = S_WRITE;
      end
      S_READ:  if (r_idx == IDX_LAST) w_next = S_LAST;
      S_LAST:  w_next = S_DONE;
      S_WRITE: if (r_idx == IDX_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    load_valid = 1'b0;
    store_done = 1'b0;
    stall      = w_active | ((r_state == S_IDLE) & w_start);
    unique case (r_state)
      S_READ: begin
        mem_re   = 1'b1;
        mem_addr = r_base + ADDR_W'(r_idx);
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = r_base + ADDR_W'(r_idx);
        mem_wdata = r_sv[r_idx];
      end
      S_DONE: begin
        load_valid = r_is_load;
        store_done = ~r_is_load;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx     <= '0;
      r_base    <= '0;
      r_is_load <= 1'b0;
      r_perr    <= 1'b0;
      r_busy    <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_sv[i]  <= '0;
        r_buf[i] <= '0;
        r_lv[i]  <= '0;
      end
    end else begin
      if (stall && r_busy != '1) r_busy <= r_busy + 19'd1;
      if (w_active && w_start) r_perr <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (start_load && start_store) r_perr <= 1'b1;
          if (w_start) begin
            r_base    <= base_addr;
            r_idx     <= '0;
            r_is_load <= start_load;
            if (!start_load)
              for (int i = 0; i < LANES; i++)
                r_sv[i] <= store_vec[i*DATA_W +: DATA_W];
          end
        end
        S_READ: begin
          // read data trails the strobe by a cycle
          if (r_idx != '0) r_buf[w_prev] <= mem_rdata;
          r_idx <= r_idx + IW'(1);
        end
        S_LAST: begin
          for (int i = 0; i < LANES - 1; i++)
            r_lv[i] <= r_buf[i];
          r_lv[LANES-1] <= mem_rdata;
        end
        S_WRITE: r_idx <= r_idx + IW'(1);
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lv
    assign load_vec[g*DATA_W +: DATA_W] = r_lv[g];
  end

  assign proto_err  = r_perr;
  assign busy_count = r_busy;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a one-cycle-latency
// memory model; checks are immediate assertions.
module tb_vector_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_load;
  logic        start_store;
  logic [15:0] base_addr;
  logic [63:0] store_vec;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        stall;
  logic [63:0] load_vec;
  logic        load_valid;
  logic        store_done;
  logic        proto_err;
  logic [18:0] busy_count;

  logic [15:0] rom [0:65535];
  int wcount = 0;
  int sd_cnt = 0;
  int ovl    = 0;
  int npass  = 0;
  int ntot   = 0;
  int wc0;
  int sd0;

  vector_mem_sequencer #(.LANES(4), .DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .start_load(start_load), .start_store(start_store),
    .base_addr(base_addr), .store_vec(store_vec),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .stall(stall), .load_vec(load_vec),
    .load_valid(load_valid), .store_done(store_done),
    .proto_err(proto_err), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= rom[mem_addr];
    if (mem_we) wcount <= wcount + 1;
    if (store_done) sd_cnt <= sd_cnt + 1;
    if (mem_re && mem_we) ovl <= ovl + 1;
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s: got %h expected %h", tag, o, e);
  endtask

  task automatic run_load(input logic [15:0] base,
                          input logic [63:0] exp, input int inj);
    logic [15:0] a;
    @(negedge clk);
    base_addr  = base;
    start_load = 1'b1;
    start_store = (inj == 0);
    store_vec  = 64'h9999_9999_9999_9999;
    #1 chk("ld_stall_c0", 64'(stall), 64'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start_load  = 1'b0;
      start_store = (inj == c);
      #1;
      if (c <= 4) begin
        a = base + 16'(c - 1);
        chk("ld_re", 64'(mem_re), 64'd1);
        chk("ld_addr", 64'(mem_addr), 64'(a));
        chk("ld_we", 64'(mem_we), 64'd0);
      end
      if (c == 5) begin
        chk("ld_last_re", 64'(mem_re), 64'd0);
        chk("ld_last_stall", 64'(stall), 64'd1);
        chk("ld_last_valid", 64'(load_valid), 64'd0);
      end
      if (c == 6) begin
        chk("ld_valid", 64'(load_valid), 64'd1);
        chk("ld_vec", load_vec, exp);
        chk("ld_done_stall", 64'(stall), 64'd0);
      end
    end
    @(negedge clk);
    start_store = 1'b0;
    #1 chk("ld_valid_pulse", 64'(load_valid), 64'd0);
    chk("ld_vec_hold", load_vec, exp);
  endtask

  task automatic run_store(input logic [15:0] base,
                           input logic [63:0] vec);
    logic [15:0] a;
    @(negedge clk);
    base_addr   = base;
    store_vec   = vec;
    start_store = 1'b1;
    #1 chk("st_stall_c0", 64'(stall), 64'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start_store = 1'b0;
      store_vec   = '0;
      #1;
      a = base + 16'(c - 1);
      chk("st_we", 64'(mem_we), 64'd1);
      chk("st_addr", 64'(mem_addr), 64'(a));
      chk("st_wdata", 64'(mem_wdata), 64'(vec[(c-1)*16 +: 16]));
      chk("st_re", 64'(mem_re), 64'd0);
    end
    @(negedge clk);
    #1 chk("st_done", 64'(store_done), 64'd1);
    chk("st_done_we", 64'(mem_we), 64'd0);
    chk("st_done_re", 64'(mem_re), 64'd0);
    chk("st_done_stall", 64'(stall), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    start_load = 1'b0;
    start_store = 1'b0;
    base_addr = '0;
    store_vec = '0;
    rom[16'h0100] = 16'h1111;
    rom[16'h0101] = 16'h2222;
    rom[16'h0102] = 16'h3333;
    rom[16'h0103] = 16'h4444;
    rom[16'h0200] = 16'h5555;
    rom[16'h0201] = 16'h6666;
    rom[16'h0202] = 16'h7777;
    rom[16'h0203] = 16'h8888;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_re", 64'(mem_re), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_vec", load_vec, 64'd0);
    chk("rst_valid", 64'(load_valid), 64'd0);
    chk("rst_done", 64'(store_done), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    chk("rst_busy", 64'(busy_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rel_stall", 64'(stall), 64'd0);

    run_load(16'h0100, 64'h4444_3333_2222_1111, -1);
    chk("busy_after_ld", 64'(busy_count), 64'd6);

    run_store(16'hFFFE, 64'hDDDD_CCCC_BBBB_AAAA);
    chk("busy_after_st", 64'(busy_count), 64'd11);
    chk("st_wcount", 64'(wcount), 64'd4);
    chk("st_perr", 64'(proto_err), 64'd0);

    wc0 = wcount;
    run_load(16'h0100, 64'h4444_3333_2222_1111, 0);
    chk("both_no_write", 64'(wcount), 64'(wc0));
    chk("both_perr", 64'(proto_err), 64'd1);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst2_perr", 64'(proto_err), 64'd0);
    chk("rst2_vec", load_vec, 64'd0);

    wc0 = wcount;
    run_load(16'h0200, 64'h8888_7777_6666_5555, 2);
    chk("busy_ld_no_write", 64'(wcount), 64'(wc0));
    chk("busy_ld_perr", 64'(proto_err), 64'd1);

    wc0 = wcount;
    sd0 = sd_cnt;
    @(negedge clk);
    base_addr   = 16'h0300;
    store_vec   = 64'h1234_5678_9ABC_DEF0;
    start_store = 1'b1;
    @(negedge clk);
    start_store = 1'b0;
    #1 chk("mid_we_c1", 64'(mem_we), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_we_drop", 64'(mem_we), 64'd0);
    chk("mid_stall_drop", 64'(stall), 64'd0);
    chk("mid_vec_clr", load_vec, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #1 chk("mid_no_done", 64'(sd_cnt), 64'(sd0));
    chk("mid_one_write", 64'(wcount), 64'(wc0 + 1));
    chk("mid_busy_rst", 64'(busy_count), 64'd0);

    run_load(16'h0100, 64'h4444_3333_2222_1111, -1);
    chk("no_overlap", 64'(ovl), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
